// File: rtl/trigger_delay_gen.sv
// trigger_delay_gen: multi-channel programmable trigger delay and pulse generator
module trigger_delay_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int MISS_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         trigger_in,
  input  logic [NUM_CH-1:0]         arm,
  input  logic [NUM_CH-1:0]         auto_rearm,
  input  logic [NUM_CH*CNT_W-1:0]   delay,
  input  logic [NUM_CH*CNT_W-1:0]   width,
  output logic [NUM_CH-1:0]         trigger_out,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH*MISS_W-1:0]  missed_cnt
);
  typedef enum logic [1:0] {IDLE, DLY, PULSE, DONE} state_t;
  logic [NUM_CH-1:0] trig_q, rise;
  // trigger history; reset to ones so a level held through reset is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) trig_q <= '1;
    else trig_q <= trigger_in;
  end
  assign rise = trigger_in & ~trig_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t st;
    logic [CNT_W-1:0] cnt, dl, wl, tgt;
    logic [MISS_W-1:0] miss;
    logic out;
    assign tgt = (dl == '0) ? CNT_W'(1) : dl;
    assign busy[i] = st != IDLE;
    assign trigger_out[i] = out;
    assign missed_cnt[i*MISS_W +: MISS_W] = miss;
    // per-channel sequencer: idle, count delay, hold pulse or level, optionally park
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st <= IDLE;
        cnt <= '0;
        dl <= '0;
        wl <= '0;
        miss <= '0;
        out <= 1'b0;
      end else if (!enable) begin
        st <= IDLE;
        cnt <= '0;
        out <= 1'b0;
      end else begin
        if (rise[i] && st != IDLE && miss != '1) miss <= miss + 1'b1;
        unique case (st)
          IDLE: if (rise[i]) begin
            st <= DLY;
            cnt <= CNT_W'(1);
            dl <= delay[i*CNT_W +: CNT_W];
            wl <= width[i*CNT_W +: CNT_W];
          end
          DLY: if (cnt == tgt) begin
            st <= PULSE;
            cnt <= CNT_W'(1);
            out <= 1'b1;
          end else cnt <= cnt + 1'b1;
          PULSE: if (wl == '0) begin
            if (arm[i]) begin
              st <= IDLE;
              cnt <= '0;
              out <= 1'b0;
            end
          end else if (cnt == wl) begin
            st <= auto_rearm[i] ? IDLE : DONE;
            cnt <= '0;
            out <= 1'b0;
          end else cnt <= cnt + 1'b1;
          DONE: if (arm[i]) st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_trigger_delay_gen.sv
// tb_trigger_delay_gen: self-checking bench for trigger_delay_gen
module tb_trigger_delay_gen;
  localparam int N = 4, W = 16, M = 8;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [N-1:0] trigger_in = '0, arm = '0, auto_rearm = '0;
  logic [N*W-1:0] delay = '0, width = '0;
  logic [N-1:0] trigger_out, busy;
  logic [N*M-1:0] missed_cnt;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  trigger_delay_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .trigger_in(trigger_in), .arm(arm),
    .auto_rearm(auto_rearm), .delay(delay), .width(width), .trigger_out(trigger_out),
    .busy(busy), .missed_cnt(missed_cnt)
  );
  // reference model in absolute time: a trigger accepted at edge t fires at t+max(d,1) and ends at that + w
  logic [N-1:0] m_out, m_busy;
  logic [N*M-1:0] m_miss;
  longint cyc = 0;
  longint rise_t[N], fall_t[N];
  bit act[N], park[N], lvl[N], prv[N], rr;
  int d, w;
  always @(posedge clk or posedge reset) begin
    cyc++;
    for (int c = 0; c < N; c++) begin
      if (reset) begin
        act[c] = 0; park[c] = 0; prv[c] = 1; m_miss[c*M +: M] = '0;
      end else if (!enable) begin
        act[c] = 0; park[c] = 0; prv[c] = trigger_in[c];
      end else begin
        rr = trigger_in[c] && !prv[c];
        prv[c] = trigger_in[c];
        if ((act[c] || park[c]) && rr && m_miss[c*M +: M] != 8'hFF) m_miss[c*M +: M] = m_miss[c*M +: M] + 8'd1;
        if (park[c]) park[c] = !arm[c];
        else if (act[c]) begin
          if (lvl[c] ? (cyc > rise_t[c] && arm[c]) : (cyc == fall_t[c])) begin
            act[c] = 0;
            park[c] = !lvl[c] && !auto_rearm[c];
          end
        end else if (rr) begin
          d = int'(delay[c*W +: W]);
          w = int'(width[c*W +: W]);
          act[c] = 1;
          rise_t[c] = cyc + ((d == 0) ? 1 : d);
          fall_t[c] = rise_t[c] + w;
          lvl[c] = (w == 0);
        end
      end
      m_out[c] = act[c] && cyc >= rise_t[c];
      m_busy[c] = act[c] || park[c];
    end
  end
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; trigger_in = '0; arm = '0;
    @(negedge clk);
    reset = 1'b0; enable = 1'b1;
  endtask
  task automatic cfg(int c, int dv, int wv, bit a);
    delay[c*W +: W] = W'(dv);
    width[c*W +: W] = W'(wv);
    auto_rearm[c] = a;
  endtask
  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; trigger_in = 4'b0001;
    cfg(0, 2, 1, 1);
    repeat (2) @(negedge clk);
    checks++; if ({trigger_out, busy, missed_cnt} !== '0) begin fails++; $display("FAIL reset_state got %h exp 0", {trigger_out, busy, missed_cnt}); end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checks++; if ({trigger_out[0], busy[0]} !== 2'b00) begin fails++; $display("FAIL held_through_reset got out=%b busy=%b exp 0 0", trigger_out[0], busy[0]); end
      checks++; if ({trigger_out, busy, missed_cnt} !== {m_out, m_busy, m_miss}) begin fails++; $display("FAIL reset_model got %h exp %h", {trigger_out, busy, missed_cnt}, {m_out, m_busy, m_miss}); end
    end
    trigger_in[0] = 1'b0;
    @(negedge clk);
    trigger_in[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      trigger_in[0] = 1'b0;
      checks++; if (trigger_out[0] !== (k == 2)) begin fails++; $display("FAIL retoggle_fire k=%0d got %b exp %b", k, trigger_out[0], k == 2); end
    end
  endtask
  task automatic test_basic();
    apply_reset();
    cfg(0, 3, 2, 1);
    @(negedge clk);
    trigger_in[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      trigger_in[0] = 1'b0;
      if (k == 0) cfg(0, 7, 9, 1);
      checks++; if (trigger_out[0] !== (k >= 3 && k <= 4)) begin fails++; $display("FAIL basic_out k=%0d got %b exp %b", k, trigger_out[0], k >= 3 && k <= 4); end
      checks++; if (busy[0] !== (k <= 4)) begin fails++; $display("FAIL basic_busy k=%0d got %b exp %b", k, busy[0], k <= 4); end
      checks++; if ({trigger_out, busy, missed_cnt} !== {m_out, m_busy, m_miss}) begin fails++; $display("FAIL basic_model k=%0d got %h exp %h", k, {trigger_out, busy, missed_cnt}, {m_out, m_busy, m_miss}); end
    end
  endtask
  task automatic test_min_max();
    apply_reset();
    cfg(0, 0, 1, 1);
    @(negedge clk);
    trigger_in[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      trigger_in[0] = 1'b0;
      checks++; if (trigger_out[0] !== (k == 1)) begin fails++; $display("FAIL delay0_out k=%0d got %b exp %b", k, trigger_out[0], k == 1); end
    end
    cfg(0, 65535, 1, 1);
    trigger_in[0] = 1'b1;
    for (int k = 0; k <= 65536; k++) begin
      @(negedge clk);
      trigger_in[0] = 1'b0;
      checks++; if ({trigger_out, busy, missed_cnt} !== {m_out, m_busy, m_miss}) begin fails++; $display("FAIL maxdelay_model k=%0d got %h exp %h", k, {trigger_out, busy, missed_cnt}, {m_out, m_busy, m_miss}); end
      if (k >= 65534) begin
        checks++; if (trigger_out[0] !== (k == 65535)) begin fails++; $display("FAIL maxdelay_out k=%0d got %b exp %b", k, trigger_out[0], k == 65535); end
      end
    end
  endtask
  task automatic test_one_shot();
    apply_reset();
    cfg(0, 2, 2, 0);
    @(negedge clk);
    trigger_in[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      trigger_in[0] = 1'b0;
      checks++; if (trigger_out[0] !== (k == 2 || k == 3)) begin fails++; $display("FAIL oneshot_out k=%0d got %b exp %b", k, trigger_out[0], k == 2 || k == 3); end
    end
    checks++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL done_busy got %b exp 1", busy[0]); end
    trigger_in[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      trigger_in[0] = 1'b0;
      checks++; if (trigger_out[0] !== 1'b0) begin fails++; $display("FAIL done_no_fire k=%0d got %b exp 0", k, trigger_out[0]); end
    end
    checks++; if (missed_cnt[7:0] !== 8'd1) begin fails++; $display("FAIL done_missed got %0d exp 1", missed_cnt[7:0]); end
    arm[0] = 1'b1;
    @(negedge clk);
    arm[0] = 1'b0;
    checks++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL arm_release got busy=%b exp 0", busy[0]); end
    trigger_in[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      trigger_in[0] = 1'b0;
      checks++; if (trigger_out[0] !== (k == 2 || k == 3)) begin fails++; $display("FAIL rearmed_out k=%0d got %b exp %b", k, trigger_out[0], k == 2 || k == 3); end
    end
  endtask
  task automatic test_level();
    apply_reset();
    cfg(0, 2, 0, 0);
    @(negedge clk);
    trigger_in[0] = 1'b1;
    for (int k = 0; k < 130; k++) begin
      @(negedge clk);
      trigger_in[0] = 1'b0;
      if (k == 1) arm[0] = 1'b1;
      if (k == 2) arm[0] = 1'b0;
      checks++; if (trigger_out[0] !== (k >= 2)) begin fails++; $display("FAIL level_out k=%0d got %b exp %b", k, trigger_out[0], k >= 2); end
      checks++; if ({trigger_out, busy, missed_cnt} !== {m_out, m_busy, m_miss}) begin fails++; $display("FAIL level_model k=%0d got %h exp %h", k, {trigger_out, busy, missed_cnt}, {m_out, m_busy, m_miss}); end
    end
    arm[0] = 1'b1;
    @(negedge clk);
    arm[0] = 1'b0;
    checks++; if ({trigger_out[0], busy[0]} !== 2'b00) begin fails++; $display("FAIL level_arm got out=%b busy=%b exp 0 0", trigger_out[0], busy[0]); end
    cfg(0, 10, 3, 1);
    trigger_in[0] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      trigger_in[0] = 1'b0;
      if (k == 2) enable = 1'b0;
      if (k == 3) begin
        checks++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL disable_busy got %b exp 0", busy[0]); end
      end
      checks++; if (trigger_out[0] !== 1'b0) begin fails++; $display("FAIL disable_out k=%0d got %b exp 0", k, trigger_out[0]); end
    end
    enable = 1'b1;
  endtask
  task automatic test_reset_mid_pulse();
    apply_reset();
    cfg(0, 1, 50, 1);
    @(negedge clk);
    trigger_in[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      trigger_in[0] = 1'b0;
    end
    checks++; if (trigger_out[0] !== 1'b1) begin fails++; $display("FAIL mid_pulse_high got %b exp 1", trigger_out[0]); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({trigger_out, busy} !== '0) begin fails++; $display("FAIL async_reset got %h exp 0", {trigger_out, busy}); end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++; if (trigger_out[0] !== 1'b0) begin fails++; $display("FAIL post_reset_glitch got %b exp 0", trigger_out[0]); end
    end
  endtask
  task automatic test_channels();
    int dv[N] = '{1, 5, 9, 13};
    logic [N-1:0] e;
    apply_reset();
    for (int c = 0; c < N; c++) cfg(c, dv[c], 1, 1);
    @(negedge clk);
    trigger_in = '1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      trigger_in = '0;
      for (int c = 0; c < N; c++) e[c] = (k == dv[c]);
      checks++; if (trigger_out !== e) begin fails++; $display("FAIL channels_out k=%0d got %b exp %b", k, trigger_out, e); end
    end
  endtask
  task automatic test_saturate();
    apply_reset();
    cfg(0, 1000, 1, 1);
    for (int i = 0; i <= 300; i++) begin
      @(negedge clk);
      trigger_in[0] = 1'b1;
      @(negedge clk);
      trigger_in[0] = 1'b0;
      checks++; if ({trigger_out, busy, missed_cnt} !== {m_out, m_busy, m_miss}) begin fails++; $display("FAIL sat_model i=%0d got %h exp %h", i, {trigger_out, busy, missed_cnt}, {m_out, m_busy, m_miss}); end
    end
    checks++; if (missed_cnt[7:0] !== 8'd255) begin fails++; $display("FAIL saturate got %0d exp 255", missed_cnt[7:0]); end
    checks++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL sat_busy got %b exp 1", busy[0]); end
  endtask
  task automatic test_back_to_back();
    apply_reset();
    cfg(0, 1, 2, 1);
    cfg(1, 1, 2, 1);
    @(negedge clk);
    trigger_in = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      trigger_in = (k == 2) ? 4'b0001 : (k == 3) ? 4'b0010 : 4'b0000;
      if (k == 6) begin
        checks++; if (missed_cnt[7:0] !== 8'd1) begin fails++; $display("FAIL exit_edge_missed got %0d exp 1", missed_cnt[7:0]); end
        checks++; if (missed_cnt[15:8] !== 8'd0) begin fails++; $display("FAIL next_cycle_missed got %0d exp 0", missed_cnt[15:8]); end
        checks++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL exit_edge_busy got %b exp 0", busy[0]); end
      end
      checks++; if (trigger_out[1] !== (k == 1 || k == 2 || k == 5 || k == 6)) begin fails++; $display("FAIL b2b_out k=%0d got %b exp %b", k, trigger_out[1], k == 1 || k == 2 || k == 5 || k == 6); end
    end
  endtask
  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      checks++; if ({trigger_out, busy, missed_cnt} !== {m_out, m_busy, m_miss}) begin fails++; $display("FAIL random_model k=%0d got %h exp %h", k, {trigger_out, busy, missed_cnt}, {m_out, m_busy, m_miss}); end
      enable = ($urandom % 60) != 0;
      for (int c = 0; c < N; c++) begin
        arm[c] = ($urandom % 6) == 0;
        auto_rearm[c] = 1'($urandom % 2);
        delay[c*W +: W] = W'($urandom % 7);
        width[c*W +: W] = W'($urandom % 5);
        if (($urandom % 3) == 0) trigger_in[c] = ~trigger_in[c];
      end
    end
    arm = '0;
    trigger_in = '0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_min_max();
    test_one_shot();
    test_level();
    test_reset_mid_pulse();
    test_channels();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
